// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: widths, funct codes and decode helpers for the multiply/divide unit.
package mult_div_unit_pkg;
    localparam int DATA_W = 32;
    localparam int FUNCT_W = 6;
    localparam logic [FUNCT_W-1:0] FUNCT_MULT = 6'h18;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV = 6'h1a;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU = 6'h1b;

    function automatic logic funct_ok(input logic [FUNCT_W-1:0] f);
        return f == FUNCT_MULT || f == FUNCT_MULTU || f == FUNCT_DIV || f == FUNCT_DIVU;
    endfunction

    function automatic logic funct_div(input logic [FUNCT_W-1:0] f);
        return f == FUNCT_DIV || f == FUNCT_DIVU;
    endfunction

    function automatic logic funct_signed(input logic [FUNCT_W-1:0] f);
        return f == FUNCT_MULT || f == FUNCT_DIV;
    endfunction
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 shift-add multiplier / restoring divider sharing
// one 64-bit working register, one adder/subtractor and one counter.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FUNCT_W-1:0]    funct,
    input  logic [DATA_W-1:0]     operand_1,
    input  logic [DATA_W-1:0]     operand_2,
    input  logic                  cancel,
    output logic                  busy,
    output logic                  mult_div_done,
    output logic [2*DATA_W-1:0]   mult_div_result
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0] state, state_next;
    logic [4:0] cnt;
    logic [63:0] acc, acc_next, fixed;
    logic [31:0] b;
    logic is_div, neg_res, neg_rem;
    logic accept, div_zero, a_neg, b_neg;
    logic [32:0] x, y;
    logic [33:0] sum;

    assign accept = start && !cancel && funct_ok(funct) && (state == S_IDLE || state == S_DONE);
    assign div_zero = accept && funct_div(funct) && operand_2 == '0;
    assign a_neg = funct_signed(funct) && operand_1[31];
    assign b_neg = funct_signed(funct) && operand_2[31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = accept ? (div_zero ? S_DONE : S_CALC) :
                     cancel ? S_IDLE :
                     state == S_CALC ? (cnt == 5'(ITER - 1) ? S_FIXUP : S_CALC) :
                     state == S_FIXUP ? S_DONE : S_IDLE;
    end

    always_comb begin
        busy = state == S_CALC || state == S_FIXUP;
        mult_div_done = state == S_DONE;
    end

    // Divide compares the shifted partial remainder (33 bits) against the divisor;
    // the extra top bit of sum is the borrow.
    always_comb begin
        x = is_div ? acc[63:31] : {1'b0, acc[63:32]};
        y = {1'b0, b};
        sum = is_div ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
        acc_next = is_div ? (!sum[33] ? {sum[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0}) :
                   (acc[0] ? {sum[32:0], acc[31:1]} : {1'b0, acc[63:1]});
        fixed = is_div ? {neg_rem ? -acc[63:32] : acc[63:32], neg_res ? -acc[31:0] : acc[31:0]} :
                (neg_res ? -acc : acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
            b <= '0;
            is_div <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            mult_div_result <= '0;
        end else if (accept) begin
            cnt <= '0;
            acc <= {32'd0, a_neg ? -operand_1 : operand_1};
            b <= b_neg ? -operand_2 : operand_2;
            is_div <= funct_div(funct);
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (div_zero) mult_div_result <= {operand_1, 32'hFFFF_FFFF};
        end else if (state == S_CALC) begin
            cnt <= cnt + 5'd1;
            acc <= acc_next;
        end else if (state == S_FIXUP && !cancel) begin
            mult_div_result <= fixed;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table vectors, randomized ops against an arithmetic model, and
// hand sequences for back-to-back, cancel, unsupported funct and async reset.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cancel = 1'b0;
    logic [5:0] funct = '0;
    logic [31:0] operand_1 = '0, operand_2 = '0;
    logic busy, mult_div_done;
    logic [63:0] mult_div_result;
    int checks = 0, failures = 0;
    logic [63:0] last_exp = '0;

    typedef struct {
        string nm;
        logic [5:0] f;
        logic [31:0] a, b;
        logic [63:0] exp;
        int lat;
    } vec_t;

    vec_t vecs[8];

    mult_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
        .operand_1(operand_1), .operand_2(operand_2), .cancel(cancel),
        .busy(busy), .mult_div_done(mult_div_done), .mult_div_result(mult_div_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        if (f == FUNCT_MULT) return 64'(sa * sb);
        if (f == FUNCT_MULTU) return {32'd0, a} * {32'd0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (f == FUNCT_DIV) return {32'(sa % sb), 32'(sa / sb)};
        return {a % b, a / b};
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        funct = f;
        operand_1 = a;
        operand_2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        operand_1 = $urandom;
        operand_2 = $urandom;
    endtask

    task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int lat = 0, busy_low = 0;
        issue(f, a, b);
        while (!mult_div_done && lat < 60) begin
            if (!busy) busy_low++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, " latency"}, 64'(lat), 64'(exp_lat));
        check({nm, " result"}, mult_div_result, exp);
        check({nm, " busy_in_done"}, 64'(busy), 64'd0);
        if (exp_lat != 0) check({nm, " busy_during"}, 64'(busy_low), 64'd0);
        last_exp = exp;
    endtask

    task automatic pulse_check(input string nm);
        @(posedge clk);
        #1;
        check({nm, " done_one_cycle"}, 64'(mult_div_done), 64'd0);
    endtask

    initial begin
        int dones;
        vecs[0] = '{"multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33};
        vecs[1] = '{"mult_neg3x7", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 33};
        vecs[2] = '{"div_neg7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[3] = '{"divu_7_2", FUNCT_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 33};
        vecs[4] = '{"divu_by0", FUNCT_DIVU, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 0};
        vecs[5] = '{"div_min_m1", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33};
        vecs[6] = '{"mult_min_min", FUNCT_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33};
        vecs[7] = '{"div_7_neg2", FUNCT_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33};

        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(mult_div_done), 64'd0);
        check("reset result", mult_div_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].nm, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
            pulse_check(vecs[i].nm);
        end

        // back-to-back: second start issued while the first is in DONE
        run_op("b2b_first", FUNCT_MULTU, 32'd12345, 32'd678, 64'd8369910, 33);
        run_op("b2b_second", FUNCT_DIVU, 32'd1000, 32'd7, {32'd6, 32'd142}, 33);
        pulse_check("b2b_second");

        // unsupported funct is ignored
        funct = 6'h20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("bad_funct busy", 64'(busy), 64'd0);
        check("bad_funct done", 64'(mult_div_done), 64'd0);

        // cancel at cycle 10 with a simultaneous start
        issue(FUNCT_MULT, 32'd55, 32'd66);
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        start = 1'b1;
        funct = FUNCT_DIVU;
        operand_1 = 32'd9;
        operand_2 = 32'd0;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        start = 1'b0;
        check("cancel busy", 64'(busy), 64'd0);
        check("cancel done_now", 64'(mult_div_done), 64'd0);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mult_div_done || busy) dones++;
        end
        check("cancel no_activity", 64'(dones), 64'd0);
        check("cancel result_held", mult_div_result, last_exp);

        // randomized ops against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [5:0] f;
            logic [31:0] a, b;
            case ($urandom_range(0, 3))
                0: f = FUNCT_MULT;
                1: f = FUNCT_MULTU;
                2: f = FUNCT_DIV;
                default: f = FUNCT_DIVU;
            endcase
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 4) == 0) b = -b;
            run_op($sformatf("rand%0d", i), f, a, b, model(f, a, b),
                   (f == FUNCT_DIV || f == FUNCT_DIVU) && b == 0 ? 0 : 33);
            if ($urandom_range(0, 1) == 1) pulse_check($sformatf("rand%0d", i));
        end

        // async reset mid-divide
        pulse_check("pre_reset");
        issue(FUNCT_DIV, 32'd1000, 32'd3);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(mult_div_done), 64'd0);
        check("rst result", mult_div_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst_divu", FUNCT_DIVU, 32'd9, 32'd4, 64'h0000_0001_0000_0002, 33);
        pulse_check("post_rst_divu");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide engine in the EX stage, directly upstream of the HI/LO write-data generator.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Presents the 64-bit product, or the {remainder, quotient} pair, on mult_div_result with a one-cycle mult_div_done pulse.
- Drives busy so the pipeline control logic can stall the front end while an operation is in flight.

Parameters:
- ITER, 32, number of radix-2 iterations; fixed to the data width, not intended to be overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on a rising edge when state is IDLE or DONE
- funct  input  `FUNCT_BUS  operation select: `FUNCT_MULT, `FUNCT_MULTU, `FUNCT_DIV or `FUNCT_DIVU
- operand_1  input  `DATA_BUS  multiplicand / dividend (rs)
- operand_2  input  `DATA_BUS  multiplier / divisor (rt)
- cancel  input  1  pipeline flush; aborts the operation in flight
- busy  output  1  high in CALC and FIXUP
- mult_div_done  output  1  one-cycle completion pulse
- mult_div_result  output  `DOUBLE_DATA_BUS  product, or {remainder[63:32], quotient[31:0]}

Behaviour:

Reset:
- rst_n low asynchronously forces state=IDLE and clears the counter and all datapath registers.
- Outputs during reset: busy=0, mult_div_done=0, mult_div_result=0.
- Reset mid-operation discards the operation; no done pulse is produced.

States:
- IDLE: waiting for a request.
- CALC: one iteration per cycle, 5-bit counter 0..31.
- FIXUP: sign correction.
- DONE: mult_div_done=1.

Accept (edge E0):
- Requires start=1, cancel=0, a supported funct, and state IDLE or DONE.
- Latches operand magnitudes, the negate-result and negate-remainder flags, and the op type.
- Clears the counter; goes to CALC.
- start with an unsupported funct is ignored.
- start while in CALC or FIXUP is ignored.

CALC:
- MULT/MULTU: shift-add. If the multiplier LSB is 1, add the multiplicand into the upper half of the 64-bit accumulator (33-bit carry); then shift the accumulator right by one.
- DIV/DIVU: restoring division on a 64-bit {rem, quo} register. Shift left one; if rem >= divisor, subtract the divisor and set quo[0]=1.
- Edges E1..E32 perform the iterations; at E32 (counter==31) go to FIXUP.

FIXUP (edge E33):
- Write mult_div_result with sign-corrected values, then go to DONE.
- MULT: negate the full 64-bit product if the operand signs differ.
- DIV: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
- MULTU/DIVU: no correction.

DONE:
- mult_div_done=1 for exactly one cycle, 33 cycles after the accept edge.
- busy=0 in DONE, so EX can advance in the same cycle.
- Next edge goes to IDLE, or to CALC if a new start is accepted (back-to-back operation).
- mult_div_result holds its value until the next FIXUP or divide-by-zero write.

Divide by zero (DIV or DIVU with operand_2==0):
- At E0, write mult_div_result={operand_1, 32'hFFFF_FFFF} and go directly to DONE.
- mult_div_done is high the cycle after E0.

Signed corner case:
- DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0; no trap.

Cancel:
- In CALC, FIXUP or DONE: next edge goes to IDLE, no (further) done pulse, mult_div_result unchanged.
- cancel and start in the same cycle: cancel wins and the request is not accepted.

Other:
- Operand inputs are don't-care after E0.
- No combinational path from inputs to outputs.

Decomposition:
- Funct codes come from funct.v; widths come from bus.v (`DATA_BUS, `DOUBLE_DATA_BUS).
- State encodings become local parameters of this module.
- No sub-module: the multiply and divide share one 64-bit working register, one 33-bit add/subtract unit and one counter inside a single module.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE_00000001; done exactly 33 cycles after accept; busy high for cycles 1..32.
- MULT -3 x 7 -> 0xFFFFFFFF_FFFFFFEB. DIV -7 / 2 -> hi 0xFFFFFFFF, lo 0xFFFFFFFD. DIVU 7 / 2 -> hi 1, lo 3.
- DIVU 100 / 0 -> result {0x00000064, 0xFFFFFFFF}; done the cycle after accept; busy never high.
- DIV 0x80000000 / 0xFFFFFFFF -> hi 0, lo 0x80000000. Back-to-back start during DONE -> second result correct, second done 33 cycles later.
- MULT started, cancel asserted at cycle 10 -> IDLE next cycle; no done; result holds its previous value. A start in the same cycle as cancel is ignored.
- rst_n pulsed low mid-DIV at cycle 15 -> busy, done and result go to 0 immediately. A new DIVU 9 / 4 after release -> hi 1, lo 2.
